det_event_logger: RTL and testbench

Downstream companion to the 010 sequence detector. It timestamps every detection pulse against a free-running cycle counter and buffers the timestamps in a small FIFO. A consumer drains them over a valid/ready interface. Overflow is reported through a sticky flag and a saturating drop counter, so software can tell when detections were lost.

---
 rtl/det_event_logger.sv | 74 +++++++
 tb/tb_det_event_logger.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/det_event_logger.sv
// Timestamps detector pulses against a free-running cycle counter and buffers them in a
// first-word-fall-through FIFO; lost events raise a sticky flag and a saturating drop count.
module det_event_logger #(
    parameter int DEPTH    = 8,
    parameter int TS_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    det_in,
    input  logic                    out_ready,
    input  logic                    clr_ovf,
    output logic                    out_valid,
    output logic [TS_WIDTH-1:0]     out_data,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    overflow,
    output logic [7:0]              drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [TS_WIDTH-1:0] ts;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [TS_WIDTH-1:0] mem [DEPTH];
    logic                pop;
    logic                push_ok;
    logic                drop;

    // NOTE: every signal here is assigned on every path, so no latch can be inferred.
    always_comb begin
        out_valid = (fifo_count != '0);
        pop       = out_valid & out_ready;
        push_ok   = det_in & ((fifo_count < FULL) | pop);
        drop      = det_in & ~push_ok;
        out_data  = out_valid ? mem[rd_ptr] : '0;
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ts         <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            ts <= ts + TS_WIDTH'(1);
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            // A drop in the same cycle as a clear restarts the tally at one.
            if (drop) begin
                overflow <= 1'b1;
                if (clr_ovf)                  drop_count <= 8'd1;
                else if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            end else if (clr_ovf) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end
        end
    end

    // NOTE: storage has no reset; fifo_count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (rst && push_ok) mem[wr_ptr] <= ts;
    end

endmodule

// File: tb/tb_det_event_logger.sv
// Drives a 16-bit and a 4-bit timestamp instance with identical stimulus and compares both
// against a queue-based model of the logger.
`timescale 1ns/1ps
module tb_det_event_logger;
    localparam int DEPTH = 8;

    logic clk_tb = 1'b0;
    logic rst = 1'b0, det_in = 1'b0, out_ready = 1'b0, clr_ovf = 1'b0;

    logic        valid_a, valid_b, ovf_a, ovf_b;
    logic [15:0] data_a;
    logic [3:0]  data_b;
    logic [3:0]  count_a, count_b;
    logic [7:0]  drops_a, drops_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: stored timestamps as absolute cycle counts since the last reset.
    int q[$];
    int m_ts    = 0;
    bit m_ovf   = 1'b0;
    int m_drops = 0;

    det_event_logger #(.DEPTH(DEPTH), .TS_WIDTH(16)) dut_a (
        .clk(clk_tb), .rst(rst), .det_in(det_in), .out_ready(out_ready), .clr_ovf(clr_ovf),
        .out_valid(valid_a), .out_data(data_a), .fifo_count(count_a),
        .overflow(ovf_a), .drop_count(drops_a)
    );

    det_event_logger #(.DEPTH(DEPTH), .TS_WIDTH(4)) dut_b (
        .clk(clk_tb), .rst(rst), .det_in(det_in), .out_ready(out_ready), .clr_ovf(clr_ovf),
        .out_valid(valid_b), .out_data(data_b), .fifo_count(count_b),
        .overflow(ovf_b), .drop_count(drops_b)
    );

    initial forever #5 clk_tb = ~clk_tb;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [15:0] exp_data_a();
        return (q.size() != 0) ? 16'(q[0]) : 16'd0;
    endfunction

    function automatic logic [3:0] exp_data_b();
        return (q.size() != 0) ? 4'(q[0]) : 4'd0;
    endfunction

    task automatic model_step(input logic d, input logic r, input logic c, input logic rv);
        bit pop, push, drop;
        if (!rv) begin
            q.delete();
            m_ts    = 0;
            m_ovf   = 1'b0;
            m_drops = 0;
            return;
        end
        pop  = (q.size() != 0) && r;
        push = d && ((q.size() < DEPTH) || pop);
        drop = d && !push;
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(m_ts);
        if (drop) begin
            m_ovf   = 1'b1;
            m_drops = c ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
        end else if (c) begin
            m_ovf   = 1'b0;
            m_drops = 0;
        end
        m_ts++;
    endtask

    // Drive one cycle's inputs after a falling edge, advance the model, land on the next falling edge.
    task automatic tick(input logic d, input logic r, input logic c, input logic rv);
        det_in = d; out_ready = r; clr_ovf = c; rst = rv;
        model_step(d, r, c, rv);
        @(posedge clk_tb);
        @(negedge clk_tb);
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++; if ({valid_a, valid_b} !== 2'b00) begin n_fail++; $display("FAIL reset_valid: got %b expected 00", {valid_a, valid_b}); end
        n_checks++; if (data_a !== 16'd0 || data_b !== 4'd0) begin n_fail++; $display("FAIL reset_data: got %0d/%0d expected 0/0", data_a, data_b); end
        n_checks++; if (count_a !== 4'd0 || count_b !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d/%0d expected 0/0", count_a, count_b); end
        n_checks++; if ({ovf_a, ovf_b} !== 2'b00) begin n_fail++; $display("FAIL reset_ovf: got %b expected 00", {ovf_a, ovf_b}); end
        n_checks++; if (drops_a !== 8'd0 || drops_b !== 8'd0) begin n_fail++; $display("FAIL reset_drops: got %0d/%0d expected 0/0", drops_a, drops_b); end
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        n_checks++; if (valid_a !== 1'b1 || data_a !== 16'd0 || data_b !== 4'd0) begin n_fail++; $display("FAIL first_ts: got v=%b %0d/%0d expected v=1 0/0", valid_a, data_a, data_b); end
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        n_checks++; if (valid_a !== 1'b0 || count_a !== 4'd0) begin n_fail++; $display("FAIL first_drain: got v=%b c=%0d expected v=0 c=0", valid_a, count_a); end
    endtask

    task automatic test_single_hold();
        do_reset();
        while (m_ts != 5) tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (valid_a !== 1'b1 || data_a !== 16'd5 || data_b !== 4'd5 || count_a !== 4'd1) begin
                n_fail++; $display("FAIL hold_%0d: got v=%b d=%0d/%0d c=%0d expected v=1 d=5/5 c=1", i, valid_a, data_a, data_b, count_a);
            end
            if (i < 3) tick(1'b0, 1'b0, 1'b0, 1'b1);
        end
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        n_checks++; if (valid_a !== 1'b0 || count_a !== 4'd0 || data_a !== 16'd0) begin n_fail++; $display("FAIL hold_pop: got v=%b c=%0d d=%0d expected v=0 c=0 d=0", valid_a, count_a, data_a); end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        while (m_ts <= 20) tick((m_ts >= 2) && (m_ts % 2 == 0), 1'b0, 1'b0, 1'b1);
        n_checks++; if (count_a !== 4'd8 || count_b !== 4'd8) begin n_fail++; $display("FAIL fill_count: got %0d/%0d expected 8/8", count_a, count_b); end
        n_checks++; if (ovf_a !== 1'b1 || drops_a !== 8'd2) begin n_fail++; $display("FAIL fill_ovf: got o=%b d=%0d expected o=1 d=2", ovf_a, drops_a); end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (valid_a !== 1'b1 || data_a !== 16'(2 + 2 * i) || data_b !== 4'(2 + 2 * i)) begin
                n_fail++; $display("FAIL drain_%0d: got v=%b %0d/%0d expected v=1 %0d", i, valid_a, data_a, data_b, 2 + 2 * i);
            end
            tick(1'b0, 1'b1, 1'b0, 1'b1);
        end
        n_checks++; if (valid_a !== 1'b0 || count_a !== 4'd0) begin n_fail++; $display("FAIL drain_empty: got v=%b c=%0d expected v=0 c=0", valid_a, count_a); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        n_checks++; if (count_a !== 4'd8 || ovf_a !== 1'b0 || drops_a !== 8'd0) begin n_fail++; $display("FAIL full_pushpop: got c=%0d o=%b d=%0d expected c=8 o=0 d=0", count_a, ovf_a, drops_a); end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (data_a !== 16'(i + 1)) begin n_fail++; $display("FAIL b2b_entry_%0d: got %0d expected %0d", i, data_a, i + 1); end
            tick(1'b0, 1'b1, 1'b0, 1'b1);
        end
    endtask

    task automatic test_wrap_saturation();
        do_reset();
        while (m_ts != 17) tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        n_checks++; if (data_b !== 4'd1 || data_a !== 16'd17) begin n_fail++; $display("FAIL wrap_ts: got %0d/%0d expected 17/1", data_a, data_b); end
        for (int i = 0; i < 7; i++) tick(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) tick(1'b1, 1'b0, 1'b0, 1'b1);
        n_checks++; if (drops_a !== 8'd255 || drops_b !== 8'd255 || ovf_a !== 1'b1) begin n_fail++; $display("FAIL saturate: got %0d/%0d o=%b expected 255/255 o=1", drops_a, drops_b, ovf_a); end
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        n_checks++; if (ovf_a !== 1'b1 || drops_a !== 8'd1) begin n_fail++; $display("FAIL clr_with_drop: got o=%b d=%0d expected o=1 d=1", ovf_a, drops_a); end
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        n_checks++; if (ovf_a !== 1'b0 || drops_a !== 8'd0 || count_a !== 4'd8) begin n_fail++; $display("FAIL clr_only: got o=%b d=%0d c=%0d expected o=0 d=0 c=8", ovf_a, drops_a, count_a); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 9; i++) tick(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0, 1'b1);
        n_checks++; if (count_a !== 4'd3 || ovf_a !== 1'b1) begin n_fail++; $display("FAIL mid_setup: got c=%0d o=%b expected c=3 o=1", count_a, ovf_a); end
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (valid_a !== 1'b0 || data_a !== 16'd0 || count_a !== 4'd0 || ovf_a !== 1'b0 || drops_a !== 8'd0) begin
            n_fail++; $display("FAIL mid_reset: got v=%b d=%0d c=%0d o=%b dr=%0d expected all 0", valid_a, data_a, count_a, ovf_a, drops_a);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        n_checks++; if (valid_a !== 1'b1 || data_a !== 16'd0 || count_a !== 4'd1) begin n_fail++; $display("FAIL mid_restart: got v=%b d=%0d c=%0d expected v=1 d=0 c=1", valid_a, data_a, count_a); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            tick($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 31) == 0, $urandom_range(0, 199) != 0);
            n_checks++;
            if (valid_a !== (q.size() != 0) || valid_b !== (q.size() != 0)) begin
                n_fail++; $display("FAIL rnd_valid @%0d: got %b/%b expected %b", i, valid_a, valid_b, q.size() != 0);
            end
            n_checks++;
            if (data_a !== exp_data_a() || data_b !== exp_data_b()) begin
                n_fail++; $display("FAIL rnd_data @%0d: got %0d/%0d expected %0d/%0d", i, data_a, data_b, exp_data_a(), exp_data_b());
            end
            n_checks++;
            if (count_a !== 4'(q.size()) || count_b !== 4'(q.size())) begin
                n_fail++; $display("FAIL rnd_count @%0d: got %0d/%0d expected %0d", i, count_a, count_b, q.size());
            end
            n_checks++;
            if (ovf_a !== m_ovf || ovf_b !== m_ovf || drops_a !== 8'(m_drops) || drops_b !== 8'(m_drops)) begin
                n_fail++; $display("FAIL rnd_ovf @%0d: got o=%b/%b d=%0d/%0d expected o=%b d=%0d", i, ovf_a, ovf_b, drops_a, drops_b, m_ovf, m_drops);
            end
        end
    endtask

    initial begin
        @(negedge clk_tb);
        test_reset();
        test_single_hold();
        test_fill_overflow();
        test_back_to_back();
        test_wrap_saturation();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
